// File: rtl/ctrl_decode_pipe_if.sv
// ctrl_decode_pipe_if -- ID-stage inputs and the registered ID/EX control
// word of ctrl_decode_pipe, grouped as one bundle. The master drives the
// decode inputs and the slave (the decode pipe itself) drives the control word.
interface ctrl_decode_pipe_if #(
   parameter int IRQ_NUM = 4,
   parameter int CAUSE_W = 4
);
   logic               instr_valid;
   logic [31:0]        instr;
   logic               pc31;
   logic [IRQ_NUM-1:0] irq;
   logic [IRQ_NUM-1:0] irq_mask;
   logic               stall;
   logic               flush;

   logic               ex_valid;
   logic [2:0]         pcsrc;
   logic [1:0]         regdst;
   logic               regwr;
   logic               alusrc1;
   logic               alusrc2;
   logic [5:0]         alufun;
   logic               sign;
   logic               memwr;
   logic               memrd;
   logic [1:0]         memtoreg;
   logic               extop;
   logic               luop;
   logic [IRQ_NUM-1:0] irq_ack;
   logic               exc_take;
   logic [CAUSE_W-1:0] exc_cause;

   modport master (
      output instr_valid, instr, pc31, irq, irq_mask, stall, flush,
      input  ex_valid, pcsrc, regdst, regwr, alusrc1, alusrc2, alufun, sign,
             memwr, memrd, memtoreg, extop, luop, irq_ack, exc_take, exc_cause
   );

   modport slave (
      input  instr_valid, instr, pc31, irq, irq_mask, stall, flush,
      output ex_valid, pcsrc, regdst, regwr, alusrc1, alusrc2, alufun, sign,
             memwr, memrd, memtoreg, extop, luop, irq_ack, exc_take, exc_cause
   );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe -- MIPS-subset ID-stage decoder with a registered ID/EX
// control word, interrupt arbitration and a RUN/DRAIN/KERNEL trap sequencer.
// Optional macro CTRL_IRQ_SYNC_EN: adds a two-flop synchroniser on irq.
// Regdst: 0 rd, 1 rt, 2 $ra, 3 trap register. Memtoreg: 0 ALU, 1 memory, 2 PC link.
module ctrl_decode_pipe #(
   parameter int IRQ_NUM = 4,
   parameter int CAUSE_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   ctrl_decode_pipe_if.slave bus
);
   localparam logic [5:0] ALU_ADD = 6'b000000;
   localparam logic [5:0] ALU_SUB = 6'b000001;
   localparam logic [5:0] ALU_AND = 6'b011000;
   localparam logic [5:0] ALU_OR  = 6'b011110;
   localparam logic [5:0] ALU_XOR = 6'b010110;
   localparam logic [5:0] ALU_NOR = 6'b010001;
   localparam logic [5:0] ALU_SLL = 6'b100000;
   localparam logic [5:0] ALU_SRL = 6'b100001;
   localparam logic [5:0] ALU_SRA = 6'b100011;
   localparam logic [5:0] ALU_EQ  = 6'b110011;
   localparam logic [5:0] ALU_NEQ = 6'b110001;
   localparam logic [5:0] ALU_LT  = 6'b110101;
   localparam logic [5:0] ALU_LEZ = 6'b111101;
   localparam logic [5:0] ALU_LTZ = 6'b111011;
   localparam logic [5:0] ALU_GTZ = 6'b111111;

   localparam logic [2:0] PC_IRQ = 3'd4;
   localparam logic [2:0] PC_BAD = 3'd5;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_KERNEL = 2'd2
   } state_t;

   typedef struct packed {
      logic       ex_valid;
      logic [2:0] pcsrc;
      logic [1:0] regdst;
      logic       regwr;
      logic       alusrc1;
      logic       alusrc2;
      logic [5:0] alufun;
      logic       sign;
      logic       memwr;
      logic       memrd;
      logic [1:0] memtoreg;
      logic       extop;
      logic       luop;
   } ctl_t;

   state_t             state_r;
   ctl_t               ctl_r;
   logic [IRQ_NUM-1:0] pend_r;
   logic [IRQ_NUM-1:0] ack_r;
   logic               take_r;
   logic [CAUSE_W-1:0] cause_r;

   ctl_t               dec_s;
   logic               bad_s;
   logic [5:0]         op_s;
   logic [5:0]         fn_s;
   logic [IRQ_NUM-1:0] irq_in_s;
   logic [IRQ_NUM-1:0] elig_s;
   logic [IRQ_NUM-1:0] sel_s;
   logic [CAUSE_W-1:0] sel_cause_s;
   logic               irq_hit_s;

   // Trap writeback: link the faulting PC into the trap register, no memory access.
   function automatic ctl_t trap_word(input logic [2:0] src);
      ctl_t w;
      w          = '0;
      w.ex_valid = 1'b1;
      w.pcsrc    = src;
      w.regdst   = 2'd3;
      w.regwr    = 1'b1;
      w.memtoreg = 2'd2;
      return w;
   endfunction

   assign op_s = bus.instr[31:26];
   assign fn_s = bus.instr[5:0];

`ifdef CTRL_IRQ_SYNC_EN
   logic [IRQ_NUM-1:0] sync1_r;
   logic [IRQ_NUM-1:0] sync2_r;

   // Two-flop synchroniser for the asynchronous interrupt lines.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= '0;
         sync2_r <= '0;
      end else begin
         sync1_r <= bus.irq;
         sync2_r <= sync1_r;
      end
   end

   assign irq_in_s = sync2_r;
`else
   assign irq_in_s = bus.irq;
`endif

   assign elig_s    = pend_r & ~bus.irq_mask;
   assign irq_hit_s = |elig_s;

   // Lowest-index eligible line wins; cause code is line index plus one.
   always_comb begin
      sel_s       = '0;
      sel_cause_s = '0;
      for (int i = IRQ_NUM - 1; i >= 0; i--) begin
         if (elig_s[i]) begin
            sel_s       = '0;
            sel_s[i]    = 1'b1;
            sel_cause_s = CAUSE_W'(i + 32'sd1);
         end else begin
            sel_s       = sel_s;
            sel_cause_s = sel_cause_s;
         end
      end
   end

   // Instruction decode; anything outside the supported subset flags bad_s.
   always_comb begin
      dec_s          = '0;
      dec_s.ex_valid = 1'b1;
      dec_s.sign     = 1'b1;
      bad_s          = 1'b0;
      case (op_s)
         6'h00: begin
            dec_s.regwr = 1'b1;
            case (fn_s)
               6'h00:   begin dec_s.alusrc1 = 1'b1; dec_s.alufun = ALU_SLL; end
               6'h02:   begin dec_s.alusrc1 = 1'b1; dec_s.alufun = ALU_SRL; end
               6'h03:   begin dec_s.alusrc1 = 1'b1; dec_s.alufun = ALU_SRA; end
               6'h08:   begin dec_s.regwr = 1'b0; dec_s.pcsrc = 3'd3; end
               6'h09:   begin dec_s.pcsrc = 3'd3; dec_s.memtoreg = 2'd2; end
               6'h20:   dec_s.alufun = ALU_ADD;
               6'h21:   begin dec_s.alufun = ALU_ADD; dec_s.sign = 1'b0; end
               6'h22:   dec_s.alufun = ALU_SUB;
               6'h23:   begin dec_s.alufun = ALU_SUB; dec_s.sign = 1'b0; end
               6'h24:   dec_s.alufun = ALU_AND;
               6'h25:   dec_s.alufun = ALU_OR;
               6'h26:   dec_s.alufun = ALU_XOR;
               6'h27:   dec_s.alufun = ALU_NOR;
               6'h2A:   dec_s.alufun = ALU_LT;
               default: begin dec_s.regwr = 1'b0; bad_s = 1'b1; end
            endcase
         end
         6'h01:   begin dec_s.pcsrc = 3'd1; dec_s.alufun = ALU_LTZ; dec_s.extop = 1'b1; end
         6'h02:   dec_s.pcsrc = 3'd2;
         6'h03:   begin
            dec_s.pcsrc    = 3'd2;
            dec_s.regwr    = 1'b1;
            dec_s.regdst   = 2'd2;
            dec_s.memtoreg = 2'd2;
         end
         6'h04:   begin dec_s.pcsrc = 3'd1; dec_s.alufun = ALU_EQ;  dec_s.extop = 1'b1; end
         6'h05:   begin dec_s.pcsrc = 3'd1; dec_s.alufun = ALU_NEQ; dec_s.extop = 1'b1; end
         6'h06:   begin dec_s.pcsrc = 3'd1; dec_s.alufun = ALU_LEZ; dec_s.extop = 1'b1; end
         6'h07:   begin dec_s.pcsrc = 3'd1; dec_s.alufun = ALU_GTZ; dec_s.extop = 1'b1; end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F, 6'h23: begin
            dec_s.regdst  = 2'd1;
            dec_s.regwr   = 1'b1;
            dec_s.alusrc2 = 1'b1;
            dec_s.extop   = (op_s != 6'h0C) && (op_s != 6'h0F);
            dec_s.luop    = (op_s == 6'h0F);
            dec_s.sign    = (op_s != 6'h09) && (op_s != 6'h0B);
            dec_s.memrd   = (op_s == 6'h23);
            dec_s.memtoreg = (op_s == 6'h23) ? 2'd1 : 2'd0;
            dec_s.alufun  = (op_s == 6'h0A || op_s == 6'h0B) ? ALU_LT :
                            (op_s == 6'h0C) ? ALU_AND : ALU_ADD;
         end
         6'h2B:   begin dec_s.alusrc2 = 1'b1; dec_s.memwr = 1'b1; dec_s.extop = 1'b1; end
         default: bad_s = 1'b1;
      endcase
   end

   // ID/EX register, pending capture and trap sequencer in one clocked process.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_RUN;
         ctl_r   <= '0;
         pend_r  <= '0;
         ack_r   <= '0;
         take_r  <= 1'b0;
         cause_r <= '0;
      end else begin
         pend_r <= pend_r | irq_in_s;
         ack_r  <= '0;
         if (bus.flush) begin
            ctl_r   <= '0;
            take_r  <= 1'b0;
            cause_r <= '0;
         end else if (bus.stall) begin
            ctl_r   <= ctl_r;
            take_r  <= take_r;
            cause_r <= cause_r;
         end else if (!bus.instr_valid) begin
            ctl_r   <= '0;
            take_r  <= 1'b0;
            cause_r <= '0;
         end else if ((state_r == ST_RUN) && !bus.pc31 && irq_hit_s) begin
            ctl_r   <= trap_word(PC_IRQ);
            take_r  <= 1'b1;
            cause_r <= sel_cause_s;
            ack_r   <= sel_s;
            pend_r  <= (pend_r | irq_in_s) & ~sel_s;
            state_r <= ST_DRAIN;
         end else if ((state_r == ST_DRAIN) && !bus.pc31) begin
            ctl_r   <= '0;
            take_r  <= 1'b0;
            cause_r <= '0;
         end else if (bad_s) begin
            ctl_r   <= trap_word(PC_BAD);
            take_r  <= 1'b1;
            cause_r <= '0;
            case (state_r)
               ST_RUN:   state_r <= ST_DRAIN;
               ST_DRAIN: state_r <= ST_KERNEL;
               default:  state_r <= state_r;
            endcase
         end else begin
            ctl_r   <= dec_s;
            take_r  <= 1'b0;
            cause_r <= '0;
            case (state_r)
               ST_DRAIN:  state_r <= ST_KERNEL;
               ST_KERNEL: state_r <= bus.pc31 ? ST_KERNEL : ST_RUN;
               default:   state_r <= state_r;
            endcase
         end
      end
   end

   assign bus.ex_valid  = ctl_r.ex_valid;
   assign bus.pcsrc     = ctl_r.pcsrc;
   assign bus.regdst    = ctl_r.regdst;
   assign bus.regwr     = ctl_r.regwr;
   assign bus.alusrc1   = ctl_r.alusrc1;
   assign bus.alusrc2   = ctl_r.alusrc2;
   assign bus.alufun    = ctl_r.alufun;
   assign bus.sign      = ctl_r.sign;
   assign bus.memwr     = ctl_r.memwr;
   assign bus.memrd     = ctl_r.memrd;
   assign bus.memtoreg  = ctl_r.memtoreg;
   assign bus.extop     = ctl_r.extop;
   assign bus.luop      = ctl_r.luop;
   assign bus.irq_ack   = ack_r;
   assign bus.exc_take  = take_r;
   assign bus.exc_cause = cause_r;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe -- scoreboard bench for ctrl_decode_pipe: directed
// scenarios then randomized traffic, checked against a behavioural model.
module tb_ctrl_decode_pipe;
   typedef struct packed {
      logic       ex_valid;
      logic [2:0] pcsrc;
      logic [1:0] regdst;
      logic       regwr;
      logic       alusrc1;
      logic       alusrc2;
      logic [5:0] alufun;
      logic       sign;
      logic       memwr;
      logic       memrd;
      logic [1:0] memtoreg;
      logic       extop;
      logic       luop;
      logic [3:0] ack;
      logic       take;
      logic [3:0] cause;
   } exp_t;

   localparam int RUN = 0, DRAIN = 1, KERNEL = 2;
   localparam logic [31:0] I_ADD = 32'h00851020;
   localparam logic [31:0] I_LW  = 32'h8C820004;
   localparam logic [31:0] I_BAD = 32'hFC000000;
   localparam logic [5:0] VOPS [15] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
      6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F, 6'h23};
   localparam logic [5:0] VFNS [14] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21,
      6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   exp_t exp_q[$];
   exp_t care_q[$];
   exp_t cur, care, care_all, care_trap, care_bub;
   int   m_state;
   logic [3:0] m_pend, syn1, syn2;

   ctrl_decode_pipe_if #(.IRQ_NUM(4), .CAUSE_W(4)) bus ();
   ctrl_decode_pipe #(.IRQ_NUM(4), .CAUSE_W(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;

   function automatic exp_t actual();
      exp_t a;
      a = {bus.ex_valid, bus.pcsrc, bus.regdst, bus.regwr, bus.alusrc1, bus.alusrc2,
           bus.alufun, bus.sign, bus.memwr, bus.memrd, bus.memtoreg, bus.extop,
           bus.luop, bus.irq_ack, bus.exc_take, bus.exc_cause};
      return a;
   endfunction

   function automatic exp_t trap(input logic [2:0] src, input logic [3:0] cause);
      exp_t t = '0;
      t.ex_valid = 1'b1; t.pcsrc = src; t.regdst = 2'd3; t.regwr = 1'b1;
      t.memtoreg = 2'd2; t.take = 1'b1; t.cause = cause;
      return t;
   endfunction

   // Reference decode, one line per supported mnemonic.
   function automatic void bdec(input logic [31:0] ins, output exp_t d, output logic bad);
      logic [5:0] op = ins[31:26];
      logic [5:0] fn = ins[5:0];
      d = '0; d.ex_valid = 1'b1; d.sign = 1'b1; bad = 1'b0;
      if (op == 6'h00) begin
         d.regwr = 1'b1;
         case (fn)
            6'h00: begin d.alusrc1 = 1'b1; d.alufun = 6'b100000; end            // sll
            6'h02: begin d.alusrc1 = 1'b1; d.alufun = 6'b100001; end            // srl
            6'h03: begin d.alusrc1 = 1'b1; d.alufun = 6'b100011; end            // sra
            6'h08: begin d.regwr = 1'b0; d.pcsrc = 3'd3; end                    // jr
            6'h09: begin d.pcsrc = 3'd3; d.memtoreg = 2'd2; end                 // jalr
            6'h20: d.alufun = 6'b000000;                                        // add
            6'h21: begin d.alufun = 6'b000000; d.sign = 1'b0; end               // addu
            6'h22: d.alufun = 6'b000001;                                        // sub
            6'h23: begin d.alufun = 6'b000001; d.sign = 1'b0; end               // subu
            6'h24: d.alufun = 6'b011000;                                        // and
            6'h25: d.alufun = 6'b011110;                                        // or
            6'h26: d.alufun = 6'b010110;                                        // xor
            6'h27: d.alufun = 6'b010001;                                        // nor
            6'h2A: d.alufun = 6'b110101;                                        // slt
            default: bad = 1'b1;
         endcase
      end else begin
         case (op)
            6'h01: begin d.pcsrc = 3'd1; d.alufun = 6'b111011; d.extop = 1'b1; end // bltz
            6'h02: d.pcsrc = 3'd2;                                                  // j
            6'h03: begin d.pcsrc = 3'd2; d.regwr = 1'b1; d.regdst = 2'd2; d.memtoreg = 2'd2; end
            6'h04: begin d.pcsrc = 3'd1; d.alufun = 6'b110011; d.extop = 1'b1; end // beq
            6'h05: begin d.pcsrc = 3'd1; d.alufun = 6'b110001; d.extop = 1'b1; end // bne
            6'h06: begin d.pcsrc = 3'd1; d.alufun = 6'b111101; d.extop = 1'b1; end // blez
            6'h07: begin d.pcsrc = 3'd1; d.alufun = 6'b111111; d.extop = 1'b1; end // bgtz
            6'h08: begin d.regdst = 2'd1; d.regwr = 1'b1; d.alusrc2 = 1'b1; d.extop = 1'b1; end
            6'h09: begin d.regdst = 2'd1; d.regwr = 1'b1; d.alusrc2 = 1'b1; d.extop = 1'b1; d.sign = 1'b0; end
            6'h0A: begin d.regdst = 2'd1; d.regwr = 1'b1; d.alusrc2 = 1'b1; d.extop = 1'b1; d.alufun = 6'b110101; end
            6'h0B: begin d.regdst = 2'd1; d.regwr = 1'b1; d.alusrc2 = 1'b1; d.extop = 1'b1; d.alufun = 6'b110101; d.sign = 1'b0; end
            6'h0C: begin d.regdst = 2'd1; d.regwr = 1'b1; d.alusrc2 = 1'b1; d.alufun = 6'b011000; end
            6'h0F: begin d.regdst = 2'd1; d.regwr = 1'b1; d.alusrc2 = 1'b1; d.luop = 1'b1; end
            6'h23: begin d.regdst = 2'd1; d.regwr = 1'b1; d.alusrc2 = 1'b1; d.extop = 1'b1; d.memrd = 1'b1; d.memtoreg = 2'd1; end
            6'h2B: begin d.alusrc2 = 1'b1; d.memwr = 1'b1; d.extop = 1'b1; end  // sw
            default: bad = 1'b1;
         endcase
      end
   endfunction

   function automatic void model_reset();
      m_state = RUN; m_pend = 4'd0; syn1 = 4'd0; syn2 = 4'd0;
      cur = '0; care = care_all;
   endfunction

   // Drive one cycle of ID inputs, advance the model, queue the expected word.
   task automatic step(input logic v, input logic [31:0] ins, input logic p,
                       input logic [3:0] rq, input logic [3:0] mk,
                       input logic st, input logic fl);
      exp_t d;
      logic bad;
      logic [3:0] eff, elig;
      int k;
      bus.instr_valid = v; bus.instr = ins; bus.pc31 = p; bus.irq = rq;
      bus.irq_mask = mk; bus.stall = st; bus.flush = fl;
`ifdef CTRL_IRQ_SYNC_EN
      eff = syn2; syn2 = syn1; syn1 = rq;
`else
      eff = rq;
`endif
      elig = m_pend & ~mk;
      cur.ack = 4'd0;
      if (fl || (!st && !v)) begin
         cur = '0; care = care_bub;
      end else if (st) begin
         cur.ack = 4'd0;
      end else if (m_state == RUN && !p && elig != 4'd0) begin
         k = 0;
         while (!elig[k]) k++;
         cur = trap(3'd4, 4'(k + 1));
         cur.ack = 4'(1 << k);
         care = care_trap;
         m_state = DRAIN;
      end else if (m_state == DRAIN && !p) begin
         cur = '0; care = care_bub;
      end else begin
         bdec(ins, d, bad);
         if (bad) begin
            cur = trap(3'd5, 4'd0); care = care_trap;
            if (m_state == RUN) m_state = DRAIN;
            else if (m_state == DRAIN) m_state = KERNEL;
         end else begin
            cur = d; care = care_all;
            if (m_state == DRAIN) m_state = KERNEL;
            else if (m_state == KERNEL && !p) m_state = RUN;
         end
      end
      m_pend = (m_pend | eff) & ~cur.ack;
      exp_q.push_back(cur);
      care_q.push_back(care);
      @(negedge clk);
   endtask

   task automatic check_zero(input string name);
      exp_t a = actual();
      checks++;
      if (a != '0) begin
         errors++;
         $display("FAIL %s got %h expected 0", name, a);
      end
   endtask

   // Scoreboard monitor: one queued word per clock, sampled just after the edge.
   always @(posedge clk) begin
      exp_t e, c, a;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         c = care_q.pop_front();
         a = actual();
         checks++;
         if (((a ^ e) & c) != '0) begin
            errors++;
            $display("FAIL word@%0t got %h expected %h care %h", $time, a, e, c);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ins;
      logic [3:0]  msk;
      int          oi;
      care_all = '1;
      care_trap = '1;
      care_trap.alusrc1 = 1'b0; care_trap.alusrc2 = 1'b0; care_trap.alufun = 6'd0;
      care_trap.sign = 1'b0; care_trap.extop = 1'b0; care_trap.luop = 1'b0;
      care_bub = '0;
      care_bub.ex_valid = 1'b1; care_bub.pcsrc = 3'b111; care_bub.regwr = 1'b1;
      care_bub.memwr = 1'b1; care_bub.memrd = 1'b1; care_bub.ack = 4'hF; care_bub.take = 1'b1;
      model_reset();
      bus.instr_valid = 1'b0; bus.instr = 32'd0; bus.pc31 = 1'b0; bus.irq = 4'd0;
      bus.irq_mask = 4'd0; bus.stall = 1'b0; bus.flush = 1'b0;
      #1 reset = 1'b0;
      #2 check_zero("reset_outputs");
      @(negedge clk); @(negedge clk);
      reset = 1'b1;

      step(1'b1, I_LW,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0);           // lw decode
      step(1'b1, I_BAD, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);           // bad -> DRAIN
      step(1'b1, I_ADD, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);           // drained bubble
      step(1'b1, I_ADD, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);           // -> KERNEL
      step(1'b1, I_ADD, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);           // -> RUN
      step(1'b1, I_ADD, 1'b0, 4'b0110, 4'd0, 1'b0, 1'b0);        // irq capture
      step(1'b1, I_ADD, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);           // take line 1
      step(1'b1, I_ADD, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);           // DRAIN bubble
      step(1'b1, I_ADD, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);           // -> KERNEL
      step(1'b1, I_ADD, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);           // kernel, no irq
      step(1'b1, I_ADD, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);           // -> RUN
      step(1'b1, I_ADD, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);           // take line 2
      step(1'b1, I_ADD, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
      step(1'b1, I_ADD, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);           // back to RUN
      step(1'b1, I_LW,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, I_ADD, 1'b0, 4'b0001, 4'd0, 1'b1, 1'b0);
      step(1'b1, I_ADD, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);           // take line 0
      step(1'b1, I_ADD, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
      step(1'b1, I_ADD, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      step(1'b1, I_ADD, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);           // stall+flush
      step(1'b1, I_ADD, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0);     // masked pending[3]
      step(1'b1, I_BAD, 1'b0, 4'd0, 4'b1000, 1'b0, 1'b0);        // -> DRAIN
      @(posedge clk); #2;
      reset = 1'b0;
      #1 check_zero("reset_mid_drain");
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      step(1'b1, I_ADD, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);           // normal, no ack
      step(1'b1, I_LW,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

      msk = 4'd0;
      for (int n = 0; n < 800; n++) begin
         oi = $urandom_range(0, 14);
         ins = {VOPS[oi], 20'($urandom), (oi == 0) ? VFNS[$urandom_range(0, 13)] : 6'($urandom)};
         if ($urandom_range(0, 9) < 3) ins = $urandom();
         if ($urandom_range(0, 15) == 0) msk = 4'($urandom);
         step($urandom_range(0, 99) < 85, ins, $urandom_range(0, 3) == 0,
              ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0, msk,
              $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain left %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ctrl_decode_pipe.md
CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

Interface
REQ-001 SHALL have parameter IRQ_NUM, default 4, number of interrupt request lines (1..16).
REQ-002 SHALL have parameter CAUSE_W, default 4, width of exc_cause.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 instr_valid  input  1  instr holds a valid ID-stage instruction.
REQ-006 instr  input  32  instruction word; OpCode=instr[31:26], Funct=instr[5:0].
REQ-007 pc31  input  1  kernel-mode bit of the ID-stage PC.
REQ-008 irq  input  IRQ_NUM  level interrupt requests.
REQ-009 irq_mask  input  IRQ_NUM  1 = line disabled.
REQ-010 stall  input  1  hold the ID/EX control register.
REQ-011 flush  input  1  replace the next ID/EX contents with a bubble.
REQ-012 ex_valid, pcsrc[3], regdst[2], regwr, alusrc1, alusrc2, alufun[6], sign, memwr, memrd, memtoreg[2], extop, luop  output  registered ID/EX control word.
REQ-013 irq_ack  output  IRQ_NUM  one-hot, one-cycle acknowledge of the serviced line.
REQ-014 exc_take  output  1  registered; the EX-stage word is a trap (interrupt or bad instruction).
REQ-015 exc_cause  output  CAUSE_W  0 = bad instruction, k+1 = irq line k.

Function
REQ-016 Decode SHALL support lw, sw, lui, addi, addiu, andi, slti, sltiu, beq, bne, blez, bgtz, bltz, j, jal, jr, jalr, and R-type add, addu, sub, subu, and, or, xor, nor, sll, srl, sra, slt.
REQ-017 pcsrc SHALL be 0 for sequential, 1 for branch, 2 for j/jal, 3 for jr/jalr, 4 for interrupt, and 5 for bad instruction.
REQ-018 alufun SHALL be ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, PASS-A 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
REQ-019 For any opcode/funct not listed in REQ-016, the block SHALL set pcsrc=5, exc_take=1, and exc_cause=0.
REQ-020 The trap writeback SHALL drive regdst=3, regwr=1, memtoreg=2, memwr=0, and memrd=0.
REQ-021 A per-line pending register SHALL set when irq[k]=1 and clear only in the cycle irq_ack[k] is asserted.
REQ-022 An interrupt SHALL be taken when instr_valid=1, pc31=0, stall=0, flush=0, state=RUN, and (pending & ~irq_mask) is nonzero.
REQ-023 Arbitration SHALL select the lowest-index eligible line.
REQ-024 An interrupt SHALL take priority over a bad instruction in the same cycle.
REQ-025 The control word SHALL appear on the outputs 1 cycle after the ID inputs are sampled, with latency 1.
REQ-026 While stall=1, all registered outputs SHALL hold, irq_ack SHALL be 0, and pending SHALL only accumulate.
REQ-027 flush=1 SHALL load a bubble: ex_valid, regwr, memwr, memrd, and exc_take all 0, and pcsrc=0.
REQ-028 When stall and flush are both asserted, flush SHALL win.
REQ-029 instr_valid=0 SHALL load a bubble.
REQ-030 The FSM SHALL have three states: RUN, DRAIN, and KERNEL.
REQ-031 The FSM SHALL move RUN->DRAIN when a trap is loaded.
REQ-032 In DRAIN, every valid ID instruction with pc31=0 SHALL be loaded as a bubble.
REQ-033 The FSM SHALL move DRAIN->KERNEL on the first valid instruction with pc31=1.
REQ-034 In KERNEL, interrupts SHALL not be taken.
REQ-035 The FSM SHALL move KERNEL->RUN on the first valid instruction with pc31=0.
REQ-036 A bad instruction in KERNEL SHALL trap but SHALL not change state.
REQ-037 A flush in DRAIN SHALL not change state.

Reset
REQ-038 While reset=0, all outputs SHALL be 0, pending SHALL be 0, and the state SHALL be RUN, all asynchronously.
REQ-039 On release, the first control word SHALL load at the first rising edge with reset=1.
REQ-040 Reset asserted mid-trap SHALL abort DRAIN and discard pending requests.

Configuration
REQ-041 With macro CTRL_IRQ_SYNC_EN defined, irq SHALL pass through a two-flop synchroniser (reset to 0) before pending capture, adding 2 cycles of request latency.
REQ-042 Without CTRL_IRQ_SYNC_EN, irq SHALL feed pending capture directly.

Verification
REQ-043 Scenario: instr=0x8C820004 (lw), valid, no irq -> next cycle ex_valid=1, pcsrc=0, regdst=1, regwr=1, alusrc2=1, alufun=000000, memrd=1, memtoreg=1.
REQ-044 Scenario: instr=0xFC000000, pc31=0 -> pcsrc=5, exc_take=1, exc_cause=0, regdst=3, memtoreg=2, state=DRAIN.
REQ-045 Scenario: irq=4'b0110, mask=0, pc31=0 -> irq_ack=4'b0010, exc_cause=2, pcsrc=4; pending[2] remains 1 until KERNEL->RUN, then irq_ack=4'b0100.
REQ-046 Scenario: irq[0]=1 while stall=1 for 3 cycles -> outputs held, irq_ack=0; the interrupt is taken in the cycle after stall drops.
REQ-047 Scenario: stall=1 and flush=1 with an add instruction -> bubble loaded (ex_valid=0, regwr=0).
REQ-048 Scenario: reset=0 mid-DRAIN with pending=4'b1000 -> all outputs 0 immediately; after release, the valid pc31=0 instruction decodes normally with no ack.
